// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the hardwired zero register index and default widths.
package hazard_pkg;

  localparam int W_DEF    = 5;
  localparam int CW_DEF   = 16;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle of the hazard controller: the ID/EX and
// MEM fields it watches and the enables/flush strobes it drives.
// master = pipeline datapath, slave = hazard_unit.
interface hazard_unit_if #(parameter int W = hazard_pkg::W_DEF);

  logic [W-1:0] id_rs;
  logic [W-1:0] id_rt;
  logic         id_uses_rt;
  logic         ex_MemRead;
  logic [W-1:0] ex_rt;
  logic         mem_pc_src;
  logic         hold_req;

  logic         pc_write;
  logic         if_id_write;
  logic         if_id_flush;
  logic         id_ex_flush;
  logic         ex_mem_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_pc_src, hold_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_pc_src, hold_req,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush
  );

endinterface

// File: rtl/hazard_stats.sv
// Saturating hazard statistics: stall cycles and redirect events.
// Only instantiated when HAZARD_STATS_EN is defined.
module hazard_stats #(
  parameter int CW = hazard_pkg::CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          stall_inc,
  input  logic          flush_inc,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  localparam logic [CW-1:0] MAX = '1;

  // Counters: clear beats increment, both stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (clear) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // NOTE: non-blocking assignments for all flop state so every
      // register samples pre-edge values regardless of block order.
      if (stall_inc && stall_count != MAX) stall_count <= stall_count + CW'(1);
      if (flush_inc && flush_count != MAX) flush_count <= flush_count + CW'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, external holds and
// MEM-stage redirects, with combinational stall/flush outputs.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise stall_count/flush_count read as zero and stats_clear is ignored.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hz,
  input  logic          stats_clear,
  output logic [1:0]    state_out,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  state_t state, next_state;
  logic   luh;
  logic   pc_write;

  // Load-use: a load in EX writes a register the ID instruction reads.
  assign luh = hz.ex_MemRead && (hz.ex_rt != W'(ZERO_REG)) &&
               ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));

  // State register; reset aborts any stall/hold in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= next_state;
  end

  // Next state by priority: redirect > hold > load-use (masked in STALL).
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state
    // unassigned, which would infer a latch.
    next_state = RUN;
    if (hz.mem_pc_src)              next_state = REDIRECT;
    else if (hz.hold_req)           next_state = HOLD;
    else if (luh && state != STALL) next_state = STALL;
  end

  // Outputs decoded from this cycle's action; all low while in reset.
  always_comb begin
    pc_write        = 1'b0;
    hz.if_id_write  = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    if (reset) begin
      unique case (next_state)
        REDIRECT: begin
          pc_write        = 1'b1;
          hz.if_id_write  = 1'b1;
          hz.if_id_flush  = 1'b1;
          hz.id_ex_flush  = 1'b1;
          hz.ex_mem_flush = 1'b1;
        end
        HOLD, STALL: begin
          hz.id_ex_flush  = 1'b1;
        end
        default: begin
          pc_write        = 1'b1;
          hz.if_id_write  = 1'b1;
        end
      endcase
    end
  end

  assign hz.pc_write = pc_write;
  assign state_out   = state;

`ifdef HAZARD_STATS_EN
  hazard_stats #(.CW(CW)) u_stats (
    .clk         (clk),
    .reset       (reset),
    .clear       (stats_clear),
    .stall_inc   (~pc_write),
    .flush_inc   (hz.mem_pc_src),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );
`else
  logic stats_clear_unused;
  assign stats_clear_unused = stats_clear;
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a rule-level model checked every
// negative clock edge plus directed vectors with literal expectations.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int W    = 5;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stats_clear = 1'b0;
  logic [1:0]    state_out;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  hazard_unit_if #(.W(W)) hz ();

  hazard_unit #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz),
    .stats_clear (stats_clear),
    .state_out   (state_out),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Action taken in a cycle: 0 advance, 1 load-use bubble, 2 hold, 3 redirect.
  // m_last is the action committed at the previous edge (= visible state).
  int m_last  = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic bit m_luh();
    return hz.ex_MemRead && hz.ex_rt != 0 &&
           (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
  endfunction

  function automatic int m_action();
    if (hz.mem_pc_src) return 3;
    if (hz.hold_req)   return 2;
    if (m_luh() && m_last != 1) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int a;
    if (!reset) begin
      m_last  = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      a = m_action();
`ifdef HAZARD_STATS_EN
      if (stats_clear) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if ((a == 1 || a == 2) && m_stall < CMAX) m_stall++;
        if (hz.mem_pc_src && m_flush < CMAX)      m_flush++;
      end
`endif
      m_last = a;
    end
  end

  // Compare process: every negative edge, all outputs against the model.
  always @(negedge clk) begin
    int a;
    bit e_pc, e_iff, e_ief, e_emf;
    int e_st;
    if (!reset) begin
      e_pc = 0; e_iff = 0; e_ief = 0; e_emf = 0; e_st = 0;
    end else begin
      a     = m_action();
      e_pc  = (a == 0 || a == 3);
      e_iff = (a == 3);
      e_ief = (a != 0);
      e_emf = (a == 3);
      e_st  = m_last;
    end
    check("cmp_pc_write",     hz.pc_write,     e_pc);
    check("cmp_if_id_write",  hz.if_id_write,  e_pc);
    check("cmp_if_id_flush",  hz.if_id_flush,  e_iff);
    check("cmp_id_ex_flush",  hz.id_ex_flush,  e_ief);
    check("cmp_ex_mem_flush", hz.ex_mem_flush, e_emf);
    check("cmp_state",        state_out,       e_st);
    check("cmp_stall_count",  stall_count,     reset ? m_stall : 0);
    check("cmp_flush_count",  flush_count,     reset ? m_flush : 0);
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] ert, input logic psrc,
                        input logic hold, input logic clr);
    hz.id_rs      = rs;
    hz.id_rt      = rt;
    hz.id_uses_rt = uses;
    hz.ex_MemRead = mr;
    hz.ex_rt      = ert;
    hz.mem_pc_src = psrc;
    hz.hold_req   = hold;
    stats_clear   = clr;
  endtask

  // Apply one cycle of inputs just after a rising edge; return at the
  // following falling edge where outputs are sampled.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic psrc,
                       input logic hold, input logic clr);
    @(posedge clk);
    #1;
    set_in(rs, rt, uses, mr, ert, psrc, hold, clr);
    @(negedge clk);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    check("rst_pc_write",    hz.pc_write,    0);
    check("rst_id_ex_flush", hz.id_ex_flush, 0);
    check("rst_state",       state_out,      0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Normal flow
    drive(3, 4, 1, 0, 0, 0, 0, 0);
    check("run_pc_write", hz.pc_write, 1);
    check("run_state",    state_out,   0);

    // lw $5 in EX, ID reads rs=5: one bubble, then masked in STALL
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    check("luh_pc_write",    hz.pc_write,    0);
    check("luh_if_id_write", hz.if_id_write, 0);
    check("luh_id_ex_flush", hz.id_ex_flush, 1);
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    check("stall_state",    state_out,      1);
    check("stall_pc_write", hz.pc_write,    1);
    check("stall_no_flush", hz.id_ex_flush, 0);
    drive(5, 0, 0, 0, 0, 0, 0, 0);
    check("after_stall_state", state_out, 0);

    // Register 0 never stalls
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("r0_pc_write", hz.pc_write, 1);

    // rt match only counts when rt is a source
    drive(2, 7, 0, 1, 7, 0, 0, 0);
    check("rt_unused_pc_write", hz.pc_write, 1);
    drive(2, 7, 1, 1, 7, 0, 0, 0);
    check("rt_used_pc_write", hz.pc_write,    0);
    check("rt_used_flush",    hz.id_ex_flush, 1);
    drive(2, 7, 1, 0, 0, 0, 0, 0);
    check("rt_used_state", state_out, 1);

    // Load-use together with redirect: redirect wins
    drive(5, 0, 0, 1, 5, 1, 0, 0);
    check("redir_pc_write",     hz.pc_write,     1);
    check("redir_if_id_flush",  hz.if_id_flush,  1);
    check("redir_id_ex_flush",  hz.id_ex_flush,  1);
    check("redir_ex_mem_flush", hz.ex_mem_flush, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("redir_state",    state_out,       3);
    check("redir_next_pc",  hz.pc_write,     1);
    check("redir_next_emf", hz.ex_mem_flush, 0);

    // Hold for 4 cycles with a redirect in cycle 3 (counters cleared first)
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("hold1_pc_write", hz.pc_write,  0);
    check("hold1_stall_cnt", stall_count, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("hold2_state",    state_out,   2);
    check("hold2_pc_write", hz.pc_write, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    check("hold3_pc_write",     hz.pc_write,     1);
    check("hold3_ex_mem_flush", hz.ex_mem_flush, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("hold4_state",       state_out,      3);
    check("hold4_pc_write",    hz.pc_write,    0);
    check("hold4_id_ex_flush", hz.id_ex_flush, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_end_state",  state_out,   2);
    check("hold_stall_cnt",  stall_count, 3 * STATS);
    check("hold_flush_cnt",  flush_count, 1 * STATS);

    // Asynchronous reset in the middle of a STALL cycle
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    drive(5, 0, 0, 1, 5, 0, 0, 0);
    check("pre_rst_state", state_out, 1);
    #1 reset = 1'b0;
    #1;
    check("midrst_pc_write",    hz.pc_write,    0);
    check("midrst_if_id_write", hz.if_id_write, 0);
    check("midrst_state",       state_out,      0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("postrst_state",     state_out,   0);
    check("postrst_stall_cnt", stall_count, 0);
    check("postrst_flush_cnt", flush_count, 0);
    check("postrst_pc_write",  hz.pc_write, 1);

`ifdef HAZARD_STATS_EN
    // Saturation of stall_count, then clear taking priority over increment
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (CMAX + 5) @(posedge clk);
    @(negedge clk);
    check("sat_stall_cnt", stall_count, CMAX);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("clr_prio_stall_cnt", stall_count, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller driving the stall and flush inputs of the IF/ID, ID/EX and EX/MEM latches. It consumes the outputs of the ID/EX latch together with the instruction fields currently in ID and the branch/jump resolution from MEM. From these it produces:
- PC and IF/ID write enables
- per-latch flush strobes that insert bubbles

A small FSM sequences load-use stalls, external holds and control-flow redirects. Optional counters expose hazard statistics.

## Interface
Parameters:
- W, 5, register index width
- CW, 16, statistics counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  W  rs field (inst[25:21]) of instruction in ID
- id_rt  in  W  rt field (inst[20:16]) of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, beq/bne)
- ex_MemRead  in  1  m_MemRead output of ID/EX latch
- ex_rt  in  W  inst_20_16 output of ID/EX latch (load destination)
- mem_pc_src  in  1  branch taken or jump resolved in MEM this cycle
- hold_req  in  1  external freeze request (debug / slow memory)
- stats_clear  in  1  synchronous clear of statistics counters
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_flush  out  1  zero ID/EX on next edge (drives its flush input)
- ex_mem_flush  out  1  zero EX/MEM on next edge
- state_out  out  2  current FSM state encoding
- stall_count  out  CW  load-use plus hold stall cycles
- flush_count  out  CW  redirect events

## Operation
- States: RUN=0, STALL=1, HOLD=2, REDIRECT=3.
- Load-use hazard is luh = ex_MemRead && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority for the current cycle: mem_pc_src > hold_req > luh. Evaluation is combinational from inputs and state.
- Redirect (mem_pc_src=1):
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - Next state: REDIRECT.
- Hold (hold_req=1, no redirect):
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1, other flushes 0.
  - Next state: HOLD. The FSM stays in HOLD while hold_req=1.
- Load-use (luh=1, state≠STALL, no redirect/hold):
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next state: STALL.
- In STALL, luh is masked. This guarantees exactly one bubble per load-use.
- Otherwise (normal flow):
  - Outputs: pc_write=1, if_id_write=1, all flushes 0.
  - Next state: RUN.
- REDIRECT, HOLD and STALL each return to RUN on the next edge unless a new condition applies, following the priority order above.
- Register 0 never creates a hazard.
- Reset:
  - While reset=0: state=RUN, counters=0, pc_write=0, if_id_write=0, all flushes=0.
  - Normal evaluation starts on the first edge after release.

## Timing
- Stall/flush outputs are combinational and valid before the edge that samples them. There is zero added latency.
- A load-use stall costs exactly one cycle.
- A redirect kills the three younger instructions in the same edge that loads the target PC.
- hold_req asserted for N cycles gives N stall cycles.
- If mem_pc_src rises during HOLD or STALL, the redirect wins immediately and the state goes to REDIRECT.
- Asynchronous reset mid-stall aborts the stall. The FSM restarts in RUN.
- Counters update on the rising edge and saturate at 2^CW−1.
- stats_clear has priority over increment.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle with pc_write=0 outside reset.
  - flush_count increments on every cycle with mem_pc_src=1.
- HAZARD_STATS_EN undefined:
  - The counters are not instantiated.
  - stall_count and flush_count are tied to 0.
  - stats_clear is ignored.
  - Ports remain present.

## Structure
- hazard_pkg holds:
  - the state encodings RUN/STALL/HOLD/REDIRECT
  - the zero-register constant
  - the default W and CW
- One sub-module, hazard_stats, holds both saturating counters. It is instantiated only under HAZARD_STATS_EN.

## Test plan
- lw $5 in EX (ex_MemRead=1, ex_rt=5), ID add reads rs=5 → one cycle with pc_write=0, id_ex_flush=1; next cycle RUN with pc_write=1.
- ex_rt=0, ex_MemRead=1, id_rs=0 → no stall; pc_write stays 1.
- ex_rt=7, id_rt=7, id_uses_rt=0 → no stall; same with id_uses_rt=1 → one-cycle stall.
- luh and mem_pc_src both high → all three flushes=1, pc_write=1, state REDIRECT; luh ignored.
- hold_req high 4 cycles, then mem_pc_src during cycle 3 → stall in cycles 1–2, redirect in cycle 3, HOLD resumes in cycle 4. With HAZARD_STATS_EN, stall_count=3 and flush_count=1.
- reset driven low mid-STALL → outputs drop to 0 immediately; after release, state=RUN and counters=0.
